// File: rtl/ascon_hash_sequencer.sv
// ascon_hash_sequencer: control-only sequencer for an Ascon-Hash datapath.
// Steps the datapath through init, absorb, padding, finalization and the
// multi-word squeeze, and handshakes with an external permutation core.
// Optional protocol checking is built when ASCON_PROTO_CHECK_EN is defined;
// otherwise err is tied low.
module ascon_hash_sequencer #(
    parameter int ROUNDS    = 12,
    parameter int TAG_WORDS = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    output logic       busy,
    input  logic       blk_valid,
    output logic       blk_ready,
    input  logic       blk_last,
    input  logic [3:0] blk_bytes,
    output logic       init_load,
    output logic       absorb_en,
    output logic [3:0] absorb_nbytes,
    output logic       perm_start,
    output logic [3:0] perm_rounds,
    input  logic       perm_done,
    output logic       squeeze_en,
    output logic [1:0] squeeze_idx,
    output logic       hash_done,
    output logic       err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_INIT_REQ,
        S_INIT_WAIT,
        S_ABS,
        S_ABS_REQ,
        S_ABS_WAIT,
        S_PAD_REQ,
        S_PAD_WAIT,
        S_PAD,
        S_FIN_REQ,
        S_FIN_WAIT,
        S_SQZ,
        S_SQZ_REQ,
        S_SQZ_WAIT,
        S_DONE
    } state_t;

    localparam logic [1:0] LAST_IDX = 2'(TAG_WORDS - 1);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_sqzCnt;
    logic [3:0] w_bytesSat;

    // Byte counts above a full 8-byte block are clamped to a full block.
    assign w_bytesSat  = (blk_bytes > 4'd8) ? 4'd8 : blk_bytes;
    assign perm_rounds = 4'(ROUNDS);
    assign busy        = (r_state != S_IDLE);

    // State register; reset aborts any hash in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Squeeze word counter: advances after each non-final word, cleared on completion.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sqzCnt <= 2'd0;
        end else if (r_state == S_DONE) begin
            r_sqzCnt <= 2'd0;
        end else if (r_state == S_SQZ && r_sqzCnt != LAST_IDX) begin
            r_sqzCnt <= r_sqzCnt + 2'd1;
        end
    end

    // Next-state and per-step strobes; strobes default low and are raised per state.
    always_comb begin
        w_next        = r_state;
        blk_ready     = 1'b0;
        init_load     = 1'b0;
        absorb_en     = 1'b0;
        absorb_nbytes = 4'd0;
        perm_start    = 1'b0;
        squeeze_en    = 1'b0;
        squeeze_idx   = 2'd0;
        hash_done     = 1'b0;
        case (r_state)
            S_IDLE:      if (start) w_next = S_INIT;
            S_INIT: begin
                init_load = 1'b1;
                w_next    = S_INIT_REQ;
            end
            S_INIT_REQ: begin
                perm_start = 1'b1;
                w_next     = S_INIT_WAIT;
            end
            S_INIT_WAIT: if (perm_done) w_next = S_ABS;
            S_ABS: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    absorb_en     = 1'b1;
                    absorb_nbytes = blk_last ? w_bytesSat : 4'd8;
                    if (!blk_last)
                        w_next = S_ABS_REQ;
                    else if (w_bytesSat == 4'd8)
                        w_next = S_PAD_REQ;
                    else
                        w_next = S_FIN_REQ;
                end
            end
            S_ABS_REQ: begin
                perm_start = 1'b1;
                w_next     = S_ABS_WAIT;
            end
            S_ABS_WAIT:  if (perm_done) w_next = S_ABS;
            S_PAD_REQ: begin
                perm_start = 1'b1;
                w_next     = S_PAD_WAIT;
            end
            S_PAD_WAIT:  if (perm_done) w_next = S_PAD;
            S_PAD: begin
                absorb_en     = 1'b1;
                absorb_nbytes = 4'd0;
                w_next        = S_FIN_REQ;
            end
            S_FIN_REQ: begin
                perm_start = 1'b1;
                w_next     = S_FIN_WAIT;
            end
            S_FIN_WAIT:  if (perm_done) w_next = S_SQZ;
            S_SQZ: begin
                squeeze_en  = 1'b1;
                squeeze_idx = r_sqzCnt;
                w_next      = (r_sqzCnt == LAST_IDX) ? S_DONE : S_SQZ_REQ;
            end
            S_SQZ_REQ: begin
                perm_start = 1'b1;
                w_next     = S_SQZ_WAIT;
            end
            S_SQZ_WAIT:  if (perm_done) w_next = S_SQZ;
            S_DONE: begin
                hash_done = 1'b1;
                w_next    = S_IDLE;
            end
            default:     w_next = S_IDLE;
        endcase
    end

`ifdef ASCON_PROTO_CHECK_EN
    logic r_err;
    logic w_inWait;
    logic w_accept;
    logic w_errEvt;

    assign w_inWait = (r_state == S_INIT_WAIT) || (r_state == S_ABS_WAIT) ||
                      (r_state == S_PAD_WAIT)  || (r_state == S_FIN_WAIT) ||
                      (r_state == S_SQZ_WAIT);
    assign w_accept = (r_state == S_ABS) && blk_valid;
    assign w_errEvt = (w_accept && ((!blk_last && blk_bytes != 4'd8) || blk_bytes > 4'd8)) ||
                      (perm_done && !w_inWait) ||
                      (start && busy);
    assign err      = r_err;

    // Sticky protocol error; an accepted start clears it, observation only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_err <= w_errEvt;
        end else if (w_errEvt) begin
            r_err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ascon_hash_sequencer.sv
// tb_ascon_hash_sequencer: randomized self-checking bench for ascon_hash_sequencer.
// A reference model turns each message into the expected ordered list of
// datapath events (init, permutation, absorb, squeeze, done) and compares it
// with the events observed on the DUT strobes.
module tb_ascon_hash_sequencer;

    localparam int ROUNDS    = 12;
    localparam int TAG_WORDS = 4;
    localparam int EV_INIT = 1, EV_PERM = 2, EV_ABS = 3, EV_SQZ = 4, EV_DONE = 5;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       blk_valid = 1'b0;
    logic       blk_last = 1'b0;
    logic [3:0] blk_bytes = 4'd0;
    logic       perm_done = 1'b0;
    logic       busy, blk_ready, init_load, absorb_en, perm_start;
    logic       squeeze_en, hash_done, err;
    logic [3:0] absorb_nbytes, perm_rounds;
    logic [1:0] squeeze_idx;

    int   testCount = 0;
    int   failCount = 0;
    int   msgBytes[$];
    int   expQ[$];
    int   obsQ[$];
    bit   expErr;
    int   doneCount = 0;
    logic errAtDone, busyAtDone;
    int   permLat = 3;
    bit   spurDone = 1'b0;
    int   permCnt = 0;

    ascon_hash_sequencer #(.ROUNDS(ROUNDS), .TAG_WORDS(TAG_WORDS)) dut (
        .clk(clk), .rstn(rstn), .start(start), .busy(busy),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_last(blk_last),
        .blk_bytes(blk_bytes), .init_load(init_load), .absorb_en(absorb_en),
        .absorb_nbytes(absorb_nbytes), .perm_start(perm_start),
        .perm_rounds(perm_rounds), .perm_done(perm_done),
        .squeeze_en(squeeze_en), .squeeze_idx(squeeze_idx),
        .hash_done(hash_done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic int ev(input int t, input int v);
        return t * 256 + v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Permutation core stand-in: answers each perm_start after permLat cycles,
    // optionally with an extra pulse in the request cycle that must be ignored.
    initial begin
        forever begin
            @(negedge clk);
            perm_done = 1'b0;
            if (!rstn) begin
                permCnt = 0;
            end else begin
                if (permCnt == 1) perm_done = 1'b1;
                if (permCnt > 0) permCnt--;
                if (perm_start) begin
                    permCnt = permLat;
                    if (spurDone) perm_done = 1'b1;
                end
            end
        end
    end

    // Event monitor, sampled well after the negedge so input drives have settled.
    always @(negedge clk) begin
        #2;
        if (rstn) begin
            if (init_load)  obsQ.push_back(ev(EV_INIT, 0));
            if (perm_start) obsQ.push_back(ev(EV_PERM, 0));
            if (absorb_en)  obsQ.push_back(ev(EV_ABS, int'(absorb_nbytes)));
            if (squeeze_en) obsQ.push_back(ev(EV_SQZ, int'(squeeze_idx)));
            if (hash_done) begin
                obsQ.push_back(ev(EV_DONE, 0));
                doneCount++;
                errAtDone  = err;
                busyAtDone = busy;
            end
        end
    end

    // Reference model: expected event list for the message in msgBytes.
    task automatic buildExpected(input bit startBusy);
        int n;
        n = msgBytes.size();
        expQ.delete();
        expErr = spurDone || startBusy;
        expQ.push_back(ev(EV_INIT, 0));
        expQ.push_back(ev(EV_PERM, 0));
        for (int i = 0; i < n; i++) begin
            int b, eff;
            b = msgBytes[i];
            if (b > 8) expErr = 1'b1;
            if (i != n - 1) begin
                if (b != 8) expErr = 1'b1;
                expQ.push_back(ev(EV_ABS, 8));
                expQ.push_back(ev(EV_PERM, 0));
            end else begin
                eff = (b > 8) ? 8 : b;
                expQ.push_back(ev(EV_ABS, eff));
                if (eff == 8) begin
                    expQ.push_back(ev(EV_PERM, 0));
                    expQ.push_back(ev(EV_ABS, 0));
                end
            end
        end
        expQ.push_back(ev(EV_PERM, 0));
        for (int k = 0; k < TAG_WORDS; k++) begin
            expQ.push_back(ev(EV_SQZ, k));
            if (k < TAG_WORDS - 1) expQ.push_back(ev(EV_PERM, 0));
        end
        expQ.push_back(ev(EV_DONE, 0));
`ifndef ASCON_PROTO_CHECK_EN
        expErr = 1'b0;
`endif
    endtask

    task automatic startHash(input bit preValid, input bit checkLat, input bit startBusy);
        obsQ.delete();
        doneCount = 0;
        if (preValid) begin
            blk_valid = 1'b1;
            blk_bytes = 4'(msgBytes[0]);
            blk_last  = (msgBytes.size() == 1);
            @(negedge clk);
            checkOutput("readyIdle", blk_ready, 0);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("readyInit", blk_ready, 0);
        if (checkLat) begin
            checkOutput("initLoadAt1", init_load, 1);
            checkOutput("permStartNotAt1", perm_start, 0);
            checkOutput("busyAt1", busy, 1);
        end
        if (startBusy) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end else if (checkLat) begin
            @(negedge clk);
            checkOutput("permStartAt2", perm_start, 1);
            checkOutput("initLoadOffAt2", init_load, 0);
            checkOutput("readyReq", blk_ready, 0);
            checkOutput("errClearedByStart", err, 0);
        end
    endtask

    task automatic applyStimulus(input bit gaps);
        int n;
        n = msgBytes.size();
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            blk_bytes = 4'(msgBytes[i]);
            blk_last  = (i == n - 1);
            blk_valid = 1'b1;
            while (!blk_ready && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (t >= 500) begin
                checkOutput("blkReadyTimeout", 0, 1);
                blk_valid = 1'b0;
                return;
            end
            @(negedge clk);
            blk_valid = 1'b0;
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        blk_valid = 1'b0;
        blk_last  = 1'b0;
        blk_bytes = 4'd0;
    endtask

    task automatic waitDone(input string tag);
        int t, m;
        t = 0;
        while (doneCount == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        checkOutput({tag, " doneSeen"}, doneCount > 0, 1);
        repeat (2) @(negedge clk);
        checkOutput({tag, " doneCount"}, doneCount, 1);
        checkOutput({tag, " evCount"}, obsQ.size(), expQ.size());
        m = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
        for (int i = 0; i < m; i++)
            checkOutput($sformatf("%s ev%0d", tag, i), obsQ[i], expQ[i]);
        checkOutput({tag, " busyAtDone"}, busyAtDone, 1);
        checkOutput({tag, " errAtDone"}, errAtDone, expErr);
        checkOutput({tag, " idleAfter"}, busy, 0);
    endtask

    task automatic runHash(input string tag, input bit preValid, input bit checkLat,
                           input bit startBusy, input bit gaps);
        buildExpected(startBusy);
        startHash(preValid, checkLat, startBusy);
        applyStimulus(gaps);
        waitDone(tag);
    endtask

    task automatic checkAllIdle(input string tag);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " blkReady"}, blk_ready, 0);
        checkOutput({tag, " initLoad"}, init_load, 0);
        checkOutput({tag, " absorbEn"}, absorb_en, 0);
        checkOutput({tag, " absorbNbytes"}, absorb_nbytes, 0);
        checkOutput({tag, " permStart"}, perm_start, 0);
        checkOutput({tag, " permRounds"}, perm_rounds, ROUNDS);
        checkOutput({tag, " squeezeEn"}, squeeze_en, 0);
        checkOutput({tag, " squeezeIdx"}, squeeze_idx, 0);
        checkOutput({tag, " hashDone"}, hash_done, 0);
        checkOutput({tag, " err"}, err, 0);
    endtask

    initial begin
        int t;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checkAllIdle("reset");
        rstn = 1'b1;
        @(negedge clk);

        permLat = 3;
        msgBytes = '{3};
        runHash("oneBlock3", 0, 1, 0, 0);

        permLat = 2;
        msgBytes = '{0};
        runHash("emptyMsg", 0, 0, 0, 0);

        msgBytes = '{8, 8};
        runHash("twoFull", 0, 0, 0, 0);

        permLat = 1;
        msgBytes = '{5};
        runHash("preValid", 1, 0, 0, 0);

        msgBytes = '{5, 2};
        runHash("badNonLast", 0, 0, 0, 0);

        msgBytes = '{12};
        runHash("clampLast", 0, 1, 0, 0);

        // Reset during the wait between squeeze words.
        permLat = 3;
        msgBytes = '{4};
        buildExpected(0);
        startHash(0, 0, 0);
        applyStimulus(0);
        t = 0;
        while (!squeeze_en && t < 500) begin
            @(negedge clk);
            t++;
        end
        checkOutput("rstSqzSeen", squeeze_en, 1);
        @(negedge clk);
        checkOutput("rstSqzReq", perm_start, 1);
        @(negedge clk);
        #4 rstn = 1'b0;
        #1 checkAllIdle("asyncReset");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("noDoneAfterReset", doneCount, 0);

        msgBytes = '{7};
        runHash("afterReset", 0, 1, 0, 0);

        for (int r = 0; r < 20; r++) begin
            int n;
            bit preV, sBusy, gp;
            n = $urandom_range(1, 4);
            msgBytes.delete();
            for (int i = 0; i < n; i++) begin
                if (i == n - 1)
                    msgBytes.push_back($urandom_range(0, 15));
                else if ($urandom_range(0, 3) == 0)
                    msgBytes.push_back($urandom_range(0, 15));
                else
                    msgBytes.push_back(8);
            end
            permLat  = $urandom_range(1, 4);
            spurDone = ($urandom_range(0, 3) == 0);
            sBusy    = ($urandom_range(0, 4) == 0);
            preV     = $urandom_range(0, 1);
            gp       = $urandom_range(0, 1);
            runHash($sformatf("rand%0d", r), preV, 0, sBusy, gp);
        end
        spurDone = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    // Watchdog so the bench always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
